// File: rtl/alu_int_pkg.sv
// alu_int_pkg: shared lane modes, segment width and lane-top helper for the SIMD integer adder.
package alu_int_pkg;
    localparam int SEG_W = 8;
    typedef enum logic [1:0] {VEC8, VEC16, VEC32, VEC64} lane_mode_t;
    function automatic logic lane_mask(input lane_mode_t vec, input int seg);
        int n;
        n = (1 << int'(vec)) - 1;
        return (seg & n) == n;
    endfunction
endpackage

// File: rtl/seg_adder8.sv
// seg_adder8: one 8-bit segment add with carry-in, producing sum, generate and propagate.
module seg_adder8 import alu_int_pkg::*; (
    input  logic [SEG_W-1:0] a_i,
    input  logic [SEG_W-1:0] b_i,
    input  logic             ci_i,
    output logic [SEG_W-1:0] s_o,
    output logic             g_o,
    output logic             p_o
);
    assign {g_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{SEG_W{1'b0}}, ci_i};
    assign p_o = &(a_i ^ b_i);
endmodule

// File: rtl/simd_int_adder_pipe.sv
// simd_int_adder_pipe: pipelined SIMD lane adder (pairwise, 3-operand widened, 2W chain).
// Optional unsigned saturation of pairwise lanes when INT_ADDER_SAT_EN is defined.
module simd_int_adder_pipe import alu_int_pkg::*; #(
    parameter int W      = 32,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               form,
    input  logic [1:0]         vec,
`ifdef INT_ADDER_SAT_EN
    input  logic               sat,
`endif
    input  logic [W-1:0]       A,
    input  logic [W-1:0]       B,
    input  logic [W-1:0]       C,
    input  logic [W-1:0]       D,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       Y1,
    output logic [W-1:0]       Y2,
    output logic [W/SEG_W-1:0] cout
);
    localparam int NSEG = W / SEG_W;

    typedef struct packed {
        logic [W-1:0]    sac, sbd, sabc;
        logic [NSEG-1:0] gac, pac, gbd, pbd, gabc, pabc, kt;
        logic            form;
        lane_mode_t      vec;
        logic            sat;
    } s1_t;

    function automatic logic [NSEG-1:0] tops(input lane_mode_t v);
        for (int i = 0; i < NSEG; i++) tops[i] = (v == VEC64) ? (i == NSEG-1) : lane_mask(v, i);
    endfunction

    logic [W-1:0] sac_x, sbd_x, sabc_x, s_x, k_x, ks_x, bm_x;
    logic [NSEG-1:0] gac_x, pac_x, gbd_x, pbd_x, gabc_x, pabc_x, kt_x, t1, tb1;
    logic sat_x, o_adv, sv;
    s1_t s1_d, st;

`ifdef INT_ADDER_SAT_EN
    assign sat_x = sat;
`else
    assign sat_x = 1'b0;
`endif

    // A+B+C is reduced carry-save style; the shifted majority vector must not cross lane bottoms
    assign s_x  = A ^ B ^ C;
    assign k_x  = (A & B) | (A & C) | (B & C);
    assign t1   = tops(lane_mode_t'(vec));
    assign tb1  = {t1[NSEG-2:0], 1'b1};
    assign ks_x = (k_x << 1) & ~bm_x;

    for (genvar i = 0; i < NSEG; i++) begin : g_seg
        assign bm_x[SEG_W*i +: SEG_W] = {{(SEG_W-1){1'b0}}, tb1[i]};
        assign kt_x[i] = k_x[SEG_W*i + SEG_W-1];
        seg_adder8 u_ac  (.a_i(A[SEG_W*i +: SEG_W]),   .b_i(C[SEG_W*i +: SEG_W]),    .ci_i(1'b0),
                          .s_o(sac_x[SEG_W*i +: SEG_W]),  .g_o(gac_x[i]),  .p_o(pac_x[i]));
        seg_adder8 u_bd  (.a_i(B[SEG_W*i +: SEG_W]),   .b_i(D[SEG_W*i +: SEG_W]),    .ci_i(1'b0),
                          .s_o(sbd_x[SEG_W*i +: SEG_W]),  .g_o(gbd_x[i]),  .p_o(pbd_x[i]));
        seg_adder8 u_abc (.a_i(s_x[SEG_W*i +: SEG_W]), .b_i(ks_x[SEG_W*i +: SEG_W]), .ci_i(1'b0),
                          .s_o(sabc_x[SEG_W*i +: SEG_W]), .g_o(gabc_x[i]), .p_o(pabc_x[i]));
    end

    assign s1_d = '{sac: sac_x, sbd: sbd_x, sabc: sabc_x, gac: gac_x, pac: pac_x, gbd: gbd_x,
                    pbd: pbd_x, gabc: gabc_x, pabc: pabc_x, kt: kt_x, form: form,
                    vec: lane_mode_t'(vec), sat: sat_x};

    assign o_adv = !out_valid || out_ready;

    if (STAGES == 2) begin : g_s2
        logic v1_q;
        s1_t  s1_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                v1_q <= 1'b0;
                s1_q <= '0;
            end else if (in_ready) begin
                v1_q <= in_valid;
                if (in_valid) s1_q <= s1_d;
            end
        end
        assign st       = s1_q;
        assign sv       = v1_q;
        assign in_ready = !v1_q || o_adv;
    end else begin : g_s1
        assign st       = s1_d;
        assign sv       = in_valid;
        assign in_ready = o_adv;
    end

    logic [W-1:0] yac, ybd, yabc, y1h, ma, mb, y1_d, y2_d, y1_q, y2_q;
    logic [NSEG-1:0] t2, tb2, cav, cbv, ccv, cout_d, cout_q;
    logic ca, cb, cc, oa, ob, wide, sat_on, ov_q;
    logic [1:0] h;

    // Segment sums get their carry-in here; carries are cleared after each lane top
    always_comb begin
        t2  = tops(st.vec);
        tb2 = {t2[NSEG-2:0], 1'b1};
        cb  = 1'b0;
        cc  = 1'b0;
        for (int i = 0; i < NSEG; i++) begin
            ybd[SEG_W*i +: SEG_W]  = st.sbd[SEG_W*i +: SEG_W] + {{(SEG_W-1){1'b0}}, cb};
            cbv[i]                 = st.gbd[i] | (st.pbd[i] & cb);
            cb                     = cbv[i] & ~t2[i];
            yabc[SEG_W*i +: SEG_W] = st.sabc[SEG_W*i +: SEG_W] + {{(SEG_W-1){1'b0}}, cc};
            ccv[i]                 = st.gabc[i] | (st.pabc[i] & cc);
            cc                     = ccv[i] & ~t2[i];
        end
        ca = (st.vec == VEC64) && cbv[NSEG-1];
        for (int i = 0; i < NSEG; i++) begin
            yac[SEG_W*i +: SEG_W] = st.sac[SEG_W*i +: SEG_W] + {{(SEG_W-1){1'b0}}, ca};
            cav[i]                = st.gac[i] | (st.pac[i] & ca);
            ca                    = cav[i] & ~t2[i];
        end
        oa = 1'b0;
        ob = 1'b0;
        h  = 2'd0;
        for (int i = NSEG-1; i >= 0; i--) begin
            oa = t2[i] ? cav[i] : oa;
            ob = t2[i] ? cbv[i] : ob;
            h  = t2[i] ? {1'b0, st.kt[i]} + {1'b0, ccv[i]} : h;
            ma[SEG_W*i +: SEG_W]  = {SEG_W{oa}};
            mb[SEG_W*i +: SEG_W]  = {SEG_W{ob}};
            y1h[SEG_W*i +: SEG_W] = tb2[i] ? {{(SEG_W-2){1'b0}}, h} : '0;
        end
        wide   = st.form && st.vec != VEC64;
        sat_on = st.sat && !st.form && st.vec != VEC64;
        y1_d   = wide ? y1h : yac | (sat_on ? ma : '0);
        y2_d   = wide ? yabc : ybd | (sat_on ? mb : '0);
        cout_d = wide ? '0 : t2 & cav;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ov_q   <= 1'b0;
            y1_q   <= '0;
            y2_q   <= '0;
            cout_q <= '0;
        end else if (o_adv) begin
            ov_q <= sv;
            if (sv) begin
                y1_q   <= y1_d;
                y2_q   <= y2_d;
                cout_q <= cout_d;
            end
        end
    end

    assign out_valid = ov_q;
    assign Y1        = y1_q;
    assign Y2        = y2_q;
    assign cout      = cout_q;
endmodule

// File: tb/tb_simd_int_adder_pipe.sv
// tb_simd_int_adder_pipe: directed vectors plus randomized stream against a lane-arithmetic model.
module tb_simd_int_adder_pipe;
    localparam int W = 32;
    localparam int NSEG = W / 8;
    localparam int RW = 2*W + NSEG;

    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1, form = 1'b0, sat_r = 1'b0;
    logic [1:0] vec = 2'd0;
    logic [W-1:0] A = '0, B = '0, C = '0, D = '0, Y1, Y2;
    logic in_ready, out_valid;
    logic [NSEG-1:0] cout;

    int total = 0, bad = 0, n_acc = 0;
    logic [RW-1:0] q[$];
    logic held = 1'b0, saw_stall = 1'b0;
    logic [RW-1:0] held_val;

    always #5 clk = ~clk;

    simd_int_adder_pipe #(.W(W), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .form(form), .vec(vec),
`ifdef INT_ADDER_SAT_EN
        .sat(sat_r),
`endif
        .A(A), .B(B), .C(C), .D(D), .out_valid(out_valid), .out_ready(out_ready),
        .Y1(Y1), .Y2(Y2), .cout(cout)
    );

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic sat_eff();
`ifdef INT_ADDER_SAT_EN
        return sat_r;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [RW-1:0] model(input logic f, input logic [1:0] v, input logic s,
                                            input logic [W-1:0] a, b, c, d);
        logic [64:0] ws;
        logic [63:0] m, x1, x2, x3, x4, r1, r2, y1w, y2w;
        logic [NSEG-1:0] co;
        int L;
        if (v == 2'd3) begin
            ws = {1'b0, a, b} + {1'b0, c, d};
            return {ws[63:32], ws[31:0], ws[64], {(NSEG-1){1'b0}}};
        end
        L = 8 << v;
        m = (64'd1 << L) - 1;
        y1w = 0; y2w = 0; co = 0;
        for (int j = 0; j < W / L; j++) begin
            x1 = ({32'b0, a} >> (L*j)) & m;
            x2 = ({32'b0, b} >> (L*j)) & m;
            x3 = ({32'b0, c} >> (L*j)) & m;
            x4 = ({32'b0, d} >> (L*j)) & m;
            if (!f) begin
                r1 = x1 + x3;
                r2 = x2 + x4;
                co[(j+1)*L/8 - 1] = r1 > m;
                if (s && r1 > m) r1 = m;
                if (s && r2 > m) r2 = m;
                y1w |= (r1 & m) << (L*j);
                y2w |= (r2 & m) << (L*j);
            end else begin
                r1 = x1 + x2 + x3;
                y2w |= (r1 & m) << (L*j);
                y1w |= (r1 >> L) << (L*j);
            end
        end
        return {y1w[W-1:0], y2w[W-1:0], co};
    endfunction

    task automatic cycle();
        @(negedge clk);
        if (held) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_data", {Y1, Y2, cout}, held_val);
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) chk("extra_out", out_valid, 1'b0);
            else chk("stream", {Y1, Y2, cout}, q.pop_front());
        end
        if (in_valid && in_ready) begin
            q.push_back(model(form, vec, sat_eff(), A, B, C, D));
            n_acc++;
        end
        if (out_valid && !out_ready) saw_stall = 1'b1;
        held = out_valid && !out_ready;
        held_val = {Y1, Y2, cout};
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        A = $urandom; B = $urandom; C = $urandom; D = $urandom;
        form = 1'($urandom_range(0, 1));
        vec = 2'($urandom_range(0, 3));
        sat_r = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input string tag);
        int n = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while ((q.size() != 0 || out_valid) && n < 20) begin
            cycle();
            n++;
        end
        chk(tag, q.size(), 0);
        held = 1'b0;
    endtask

    task automatic direct(input string tag, input logic f, input logic [1:0] v, input logic s,
                          input logic [W-1:0] a, b, c, d, ey1, ey2, input logic [NSEG-1:0] ec);
        int lat;
        form = f; vec = v; sat_r = s; A = a; B = b; C = c; D = d;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_rdy"}, in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, 2);
        chk({tag, "_y1"}, Y1, ey1);
        chk({tag, "_y2"}, Y2, ey2);
        chk({tag, "_cout"}, cout, ec);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_y", {Y1, Y2, cout}, '0);
        chk("rst_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        direct("t1", 1'b0, 2'd0, 1'b0, 32'h80FF_0102, 32'h0101_0101, 32'h80FF_0102, 32'h0101_0101,
               32'h00FE_0204, 32'h0202_0202, 4'b1100);
        direct("t2", 1'b1, 2'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,
               32'h0000_0002, 32'hFFFF_FFFD, 4'b0000);
        direct("t3", 1'b0, 2'd3, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h1,
               32'h1, 32'h0, 4'b0000);
        direct("t3b", 1'b1, 2'd3, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1, 32'h8000_0000,
               32'h1, 32'h0, 4'b1000);
        direct("w16", 1'b1, 2'd1, 1'b0, 32'hFFFF_0001, 32'hFFFF_0001, 32'hFFFF_0001, 32'h0,
               32'h0002_0000, 32'hFFFD_0003, 4'b0000);
`ifdef INT_ADDER_SAT_EN
        direct("t6", 1'b0, 2'd1, 1'b1, 32'hFFFF_0001, 32'h0, 32'hFFFF_0001, 32'h0,
               32'hFFFF_0002, 32'h0, 4'b1000);
`endif

        saw_stall = 1'b0;
        n_acc = 0;
        for (int cyc = 0; cyc < 40 && n_acc < 8; cyc++) begin
            rand_ops();
            in_valid = 1'b1;
            out_ready = !(cyc >= 3 && cyc <= 5);
            if (cyc == 4) chk("full_ready", in_ready, 1'b0);
            cycle();
        end
        chk("stream_acc", n_acc, 8);
        chk("stream_stall", saw_stall, 1'b1);
        drain("stream_drain");

        n_acc = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            rand_ops();
            in_valid = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 3) != 0);
            cycle();
        end
        drain("rand_drain");

        n_acc = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rand_ops();
            in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        chk("inflight", n_acc, 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        held = 1'b0;
        q.delete();
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_y", {Y1, Y2, cout}, '0);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("no_stale", out_valid, 1'b0);
        end
        chk("post_rst_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        direct("after_rst", 1'b0, 2'd2, 1'b0, 32'hFFFF_FFFF, 32'h7, 32'h1, 32'h9,
               32'h0, 32'h10, 4'b1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
